// File: rtl/fb_cmd_pkg.sv
// Shared command/state types and resolution constants for the framebuffer
// writer and the double-buffered display it feeds.
package fb_cmd_pkg;

  localparam int RES_X      = 320;
  localparam int RES_Y      = 240;
  localparam int MEM_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y);
  localparam int XW         = $clog2(RES_X);
  localparam int YW         = $clog2(RES_Y);

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_RECT = 2'd1,
    OP_SWAP = 2'd2,
    OP_NOP  = 2'd3
  } fb_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_SWAP,
    S_DONE
  } fb_state_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake plus framebuffer write-port bundle of the rectangle writer.
interface fb_rect_writer_if #(
  parameter int MEM_WIDTH  = fb_cmd_pkg::MEM_WIDTH,
  parameter int ADDR_WIDTH = fb_cmd_pkg::ADDR_WIDTH,
  parameter int XW         = fb_cmd_pkg::XW,
  parameter int YW         = fb_cmd_pkg::YW
);
  import fb_cmd_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  fb_op_t                cmd_op;
  logic [XW-1:0]         cmd_x0;
  logic [YW-1:0]         cmd_y0;
  logic [XW-1:0]         cmd_x1;
  logic [YW-1:0]         cmd_y1;
  logic [MEM_WIDTH-1:0]  cmd_color;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  din;
  logic                  wen;
  logic                  swap_buf;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, mem_addr, din, wen, swap_buf, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, mem_addr, din, wen, swap_buf, busy, done
  );

endinterface

// File: rtl/fb_raster_addr_gen.sv
// Raster walker over a clamped rectangle: x inner, y outer, address kept as a
// running register so the row stride is an add rather than a multiply.
module fb_raster_addr_gen #(
  parameter int RES_X      = fb_cmd_pkg::RES_X,
  parameter int ADDR_WIDTH = fb_cmd_pkg::ADDR_WIDTH,
  parameter int XW         = fb_cmd_pkg::XW,
  parameter int YW         = fb_cmd_pkg::YW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [XW-1:0]         x0,
  input  logic [YW-1:0]         y0,
  input  logic [XW-1:0]         x1,
  input  logic [YW-1:0]         y1,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [XW-1:0]         x_lo, x_hi, x;
  logic [YW-1:0]         y_hi, y;
  logic [ADDR_WIDTH-1:0] row_base;

  // Starting row offset as a shift-add over the set bits of the constant width.
  function automatic logic [ADDR_WIDTH-1:0] row_offset(input logic [YW-1:0] row);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_WIDTH; b++)
      if (RES_X[b]) acc = acc + (ADDR_WIDTH'(row) << b);
    return acc;
  endfunction

  assign last = (x == x_hi) && (y == y_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (start) begin
      x_lo     <= x0;
      x_hi     <= x1;
      y_hi     <= y1;
      x        <= x0;
      y        <= y0;
      row_base <= row_offset(y0);
      addr     <= row_offset(y0) + ADDR_WIDTH'(x0);
    end else if (step) begin
      if (x == x_hi) begin
        x        <= x_lo;
        y        <= y + YW'(1);
        row_base <= row_base + ADDR_WIDTH'(RES_X);
        addr     <= row_base + ADDR_WIDTH'(RES_X) + ADDR_WIDTH'(x_lo);
      end else begin
        x    <= x + XW'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Command-driven back-buffer producer: FILL/RECT draw one pixel per cycle,
// SWAP pulses the buffer-swap request, every command ends with a done pulse.
module fb_rect_writer #(
  parameter int RES_X      = fb_cmd_pkg::RES_X,
  parameter int RES_Y      = fb_cmd_pkg::RES_Y,
  parameter int MEM_WIDTH  = fb_cmd_pkg::MEM_WIDTH,
  parameter int ADDR_WIDTH = fb_cmd_pkg::ADDR_WIDTH,
  parameter int XW         = fb_cmd_pkg::XW,
  parameter int YW         = fb_cmd_pkg::YW
) (
  input  logic            clk,
  input  logic            rst,
  fb_rect_writer_if.slave bus
);
  import fb_cmd_pkg::*;

  localparam logic [XW-1:0] X_MAX = XW'(RES_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(RES_Y - 1);

  fb_state_t             state, state_d;
  logic                  wen_q, wen_d;
  logic                  swap_q, swap_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [MEM_WIDTH-1:0]  din_q, din_d;
  logic                  start, step, last;
  logic [XW-1:0]         x0_c, x1_c;
  logic [YW-1:0]         y0_c, y1_c;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] gen_addr;

  // Bounds as they will be drawn; FILL is simply the full-screen rectangle.
  always_comb begin
    x0_c = bus.cmd_x0;
    y0_c = bus.cmd_y0;
    x1_c = (bus.cmd_x1 > X_MAX) ? X_MAX : bus.cmd_x1;
    y1_c = (bus.cmd_y1 > Y_MAX) ? Y_MAX : bus.cmd_y1;
    if (bus.cmd_op == OP_FILL) begin
      x0_c = '0;
      y0_c = '0;
      x1_c = X_MAX;
      y1_c = Y_MAX;
    end
    empty = (x0_c > x1_c) || (y0_c > y1_c) || (x0_c > X_MAX) || (y0_c > Y_MAX);
  end

  fb_raster_addr_gen #(
    .RES_X(RES_X), .ADDR_WIDTH(ADDR_WIDTH), .XW(XW), .YW(YW)
  ) u_gen (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .x0(x0_c), .y0(y0_c), .x1(x1_c), .y1(y1_c),
    .addr(gen_addr), .last(last)
  );

  // DONE behaves like IDLE toward the host, so a waiting command is taken there.
  always_comb begin
    state_d = state;
    wen_d   = 1'b0;
    swap_d  = 1'b0;
    din_d   = din_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_FILL, OP_RECT: begin
              if (empty) begin
                state_d = S_DONE;
              end else begin
                state_d = S_DRAW;
                wen_d   = 1'b1;
                start   = 1'b1;
                din_d   = bus.cmd_color;
              end
            end
            OP_SWAP: begin
              state_d = S_SWAP;
              swap_d  = 1'b1;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DRAW: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          wen_d = 1'b1;
          step  = 1'b1;
        end
      end
      S_SWAP:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wen_q   <= 1'b0;
      swap_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state   <= state_d;
      wen_q   <= wen_d;
      swap_q  <= swap_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      din_q   <= din_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_addr  = gen_addr;
  assign bus.din       = din_q;
  assign bus.wen       = wen_q;
  assign bus.swap_buf  = swap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: logs every write/done/swap at the falling
// edge and compares against hand-computed addresses and cycle offsets.
module tb_fb_rect_writer;
  import fb_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int wrAddr[$], wrDin[$], wrCyc[$], doneCyc[$], doneReady[$], swapCyc[$];

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wen) begin
      wrAddr.push_back(int'(bus.mem_addr));
      wrDin.push_back(int'(bus.din));
      wrCyc.push_back(cyc);
    end
    if (bus.done) begin
      doneCyc.push_back(cyc);
      doneReady.push_back(int'(bus.cmd_ready));
    end
    if (bus.swap_buf) swapCyc.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete(); wrDin.delete(); wrCyc.delete();
    doneCyc.delete(); doneReady.delete(); swapCyc.delete();
  endtask

  // Presents a command and returns the cycle in which it was accepted.
  task automatic applyStimulus(input fb_op_t op, input int x0, input int y0,
                               input int x1, input int y1, input int color,
                               input bit holdValid, output int acc);
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_x0    = XW'(x0);
    bus.cmd_y0    = YW'(y0);
    bus.cmd_x1    = XW'(x1);
    bus.cmd_y1    = YW'(y1);
    bus.cmd_color = MEM_WIDTH'(color);
    bus.cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accepted", (acc >= 0) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    if (!holdValid) bus.cmd_valid = 1'b0;
  endtask

  task automatic checkRect(input string tag, input int acc, input int expAddr[$], input int color);
    int badA, badD, badC;
    badA = 0; badD = 0; badC = 0;
    checkOutput({tag, "_count"}, wrAddr.size(), expAddr.size());
    for (int i = 0; i < wrAddr.size() && i < expAddr.size(); i++) begin
      if (wrAddr[i] != expAddr[i]) badA++;
      if (wrDin[i] != color) badD++;
      if (wrCyc[i] != acc + 1 + i) badC++;
    end
    checkOutput({tag, "_addr_errs"}, badA, 0);
    checkOutput({tag, "_din_errs"}, badD, 0);
    checkOutput({tag, "_cycle_errs"}, badC, 0);
    checkOutput({tag, "_done_count"}, doneCyc.size(), 1);
    if (doneCyc.size() > 0) begin
      checkOutput({tag, "_done_cycle"}, doneCyc[0] - acc, expAddr.size() + 1);
      checkOutput({tag, "_ready_at_done"}, doneReady[0], 1);
    end
  endtask

  initial begin
    int acc, accB, found;
    int expQ[$];

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_wen", int'(bus.wen), 0);
    checkOutput("rst_ready", int'(bus.cmd_ready), 1);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_swap", int'(bus.swap_buf), 0);
    checkOutput("rst_addr", int'(bus.mem_addr), 0);
    checkOutput("rst_din", int'(bus.din), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", int'(bus.cmd_ready), 1);

    // Full-screen fill
    clearLog();
    applyStimulus(OP_FILL, 0, 0, 0, 0, 8'h3C, 1'b0, acc);
    #2 checkOutput("fill_busy", int'(bus.busy), 1);
    checkOutput("fill_ready_low", int'(bus.cmd_ready), 0);
    repeat (76805) @(negedge clk);
    expQ.delete();
    for (int i = 0; i < 76800; i++) expQ.push_back(i);
    checkRect("fill", acc, expQ, 8'h3C);

    // Small rectangle
    clearLog();
    applyStimulus(OP_RECT, 10, 20, 12, 21, 8'hA5, 1'b0, acc);
    repeat (10) @(negedge clk);
    expQ = '{6410, 6411, 6412, 6730, 6731, 6732};
    checkRect("rect", acc, expQ, 8'hA5);
    checkOutput("rect_hold_addr", int'(bus.mem_addr), 6732);
    checkOutput("rect_hold_din", int'(bus.din), 8'hA5);

    // Clamped corner; 255 is the largest y1 the 8-bit field can carry
    clearLog();
    applyStimulus(OP_RECT, 318, 238, 400, 255, 8'h11, 1'b0, acc);
    repeat (8) @(negedge clk);
    expQ = '{76478, 76479, 76798, 76799};
    checkRect("clamp", acc, expQ, 8'h11);

    // Empty rectangles
    clearLog();
    applyStimulus(OP_RECT, 50, 5, 40, 9, 8'h22, 1'b0, acc);
    repeat (4) @(negedge clk);
    expQ.delete();
    checkRect("empty_x", acc, expQ, 8'h22);
    clearLog();
    applyStimulus(OP_RECT, 330, 0, 340, 10, 8'h22, 1'b0, acc);
    repeat (4) @(negedge clk);
    checkRect("off_screen", acc, expQ, 8'h22);

    // SWAP with valid held, then a queued RECT
    clearLog();
    applyStimulus(OP_SWAP, 0, 0, 0, 0, 0, 1'b1, acc);
    applyStimulus(OP_RECT, 1, 1, 2, 1, 8'h07, 1'b0, accB);
    repeat (6) @(negedge clk);
    checkOutput("swap_count", swapCyc.size(), 1);
    if (swapCyc.size() > 0) checkOutput("swap_cycle", swapCyc[0] - acc, 1);
    checkOutput("swap_done_count", doneCyc.size(), 2);
    if (doneCyc.size() > 0) checkOutput("swap_done_cycle", doneCyc[0] - acc, 2);
    checkOutput("queued_accept_cycle", accB - acc, 2);
    checkOutput("queued_writes", wrAddr.size(), 2);
    if (wrAddr.size() == 2) begin
      checkOutput("queued_addr0", wrAddr[0], 321);
      checkOutput("queued_addr1", wrAddr[1], 322);
      checkOutput("queued_first_cycle", wrCyc[0] - accB, 1);
    end
    if (doneCyc.size() > 1) checkOutput("queued_done_cycle", doneCyc[1] - accB, 3);

    // Reset in the middle of a fill
    clearLog();
    applyStimulus(OP_FILL, 0, 0, 0, 0, 8'h55, 1'b0, acc);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.wen && int'(bus.mem_addr) == 1000) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reached_pixel_1000", found, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_wen", int'(bus.wen), 0);
    checkOutput("abort_ready", int'(bus.cmd_ready), 1);
    checkOutput("abort_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", doneCyc.size(), 0);
    checkOutput("abort_wen_idle", int'(bus.wen), 0);

    clearLog();
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 1'b0, acc);
    repeat (3) @(negedge clk);
    expQ.delete();
    checkRect("nop", acc, expQ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
